// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg: register-file geometry shared by the writeback register file and its commit tracker.
package wb_regfile_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NUM_REGS = 32;
  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] REG_SP = 5'd2;
  typedef logic [REG_AW-1:0] reg_idx_t;
endpackage

// File: rtl/wb_commit_tracker.sv
// wb_commit_tracker: retired-instruction counter and last-commit capture for debug.
module wb_commit_tracker
  import wb_regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int CNT_W = 64
) (
  input  logic             clk_cpu,
  input  logic             rst_cpu,
  input  logic             have_inst,
  input  logic             rd_we_wb,
  input  reg_idx_t         rd_wb,
  input  logic [XLEN-1:0]  data_wb,
  input  logic [31:0]      pc_wb,
  output logic [CNT_W-1:0] instret,
  output logic [31:0]      last_pc,
  output reg_idx_t         last_rd,
  output logic [XLEN-1:0]  last_data
);
  always_ff @(posedge clk_cpu or posedge rst_cpu) begin
    if (rst_cpu) begin
      instret   <= '0;
      last_pc   <= '0;
      last_rd   <= '0;
      last_data <= '0;
    end else if (have_inst) begin
      instret   <= instret + CNT_W'(1);
      last_pc   <= pc_wb;
      last_rd   <= rd_we_wb ? rd_wb : '0;
      last_data <= (rd_we_wb && rd_wb != '0) ? data_wb : '0;
    end
  end
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: architectural register file with WB->ID write-through bypass on both read ports,
// hardwired x0, and a debug read port that sees only the committed array.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int CNT_W = 64,
  parameter logic [XLEN-1:0] SP_INIT = '0
) (
  input  logic             clk_cpu,
  input  logic             rst_cpu,
  input  logic             rd_we_wb,
  input  logic [4:0]       rd_wb,
  input  logic [XLEN-1:0]  data_wb,
  input  logic [31:0]      pc_wb,
  input  logic             have_inst,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  output logic [XLEN-1:0]  rD1,
  output logic [XLEN-1:0]  rD2,
  input  logic [4:0]       dbg_addr,
  output logic [XLEN-1:0]  dbg_data,
  output logic [CNT_W-1:0] instret,
  output logic [31:0]      last_pc,
  output logic [4:0]       last_rd,
  output logic [XLEN-1:0]  last_data
);
  logic [XLEN-1:0] r_regs [NUM_REGS];
  logic            w_wr;

  assign w_wr = rd_we_wb && rd_wb != '0;

  always_ff @(posedge clk_cpu or posedge rst_cpu) begin
    if (rst_cpu) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= (i == int'(REG_SP)) ? SP_INIT : '0;
    end else if (w_wr) begin
      r_regs[rd_wb] <= data_wb;
    end
  end

  // Bypass lets decode see the value being written back in this very cycle.
  assign rD1 = (rs1_id == '0) ? '0 : (rd_we_wb && rd_wb == rs1_id) ? data_wb : r_regs[rs1_id];
  assign rD2 = (rs2_id == '0) ? '0 : (rd_we_wb && rd_wb == rs2_id) ? data_wb : r_regs[rs2_id];
  assign dbg_data = (dbg_addr == '0) ? '0 : r_regs[dbg_addr];

  wb_commit_tracker #(.XLEN(XLEN), .CNT_W(CNT_W)) u_commit (
    .clk_cpu  (clk_cpu),
    .rst_cpu  (rst_cpu),
    .have_inst(have_inst),
    .rd_we_wb (rd_we_wb),
    .rd_wb    (rd_wb),
    .data_wb  (data_wb),
    .pc_wb    (pc_wb),
    .instret  (instret),
    .last_pc  (last_pc),
    .last_rd  (last_rd),
    .last_data(last_data)
  );
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: randomized and directed checks of wb_regfile against a behavioural model.
module tb_wb_regfile;
  localparam logic [31:0] SP = 32'h0000_8000;
  logic        clk_cpu = 0;
  logic        rst_cpu;
  logic        rd_we_wb = 0;
  logic [4:0]  rd_wb = 0;
  logic [31:0] data_wb = 0;
  logic [31:0] pc_wb = 0;
  logic        have_inst = 0;
  logic [4:0]  rs1_id = 0, rs2_id = 0, dbg_addr = 0;
  logic [31:0] rD1, rD2, dbg_data, last_pc, last_data;
  logic [63:0] instret;
  logic [4:0]  last_rd;
  logic [31:0] s_rD1, s_rD2, s_dbg, s_last_pc, s_last_data;
  logic [3:0]  s_instret;
  logic [4:0]  s_last_rd;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk_cpu = ~clk_cpu;

  wb_regfile #(.XLEN(32), .CNT_W(64), .SP_INIT(SP)) dut (
    .clk_cpu(clk_cpu), .rst_cpu(rst_cpu), .rd_we_wb(rd_we_wb), .rd_wb(rd_wb), .data_wb(data_wb),
    .pc_wb(pc_wb), .have_inst(have_inst), .rs1_id(rs1_id), .rs2_id(rs2_id), .rD1(rD1), .rD2(rD2),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .instret(instret), .last_pc(last_pc),
    .last_rd(last_rd), .last_data(last_data)
  );

  wb_regfile #(.XLEN(32), .CNT_W(4), .SP_INIT(SP)) u_small (
    .clk_cpu(clk_cpu), .rst_cpu(rst_cpu), .rd_we_wb(rd_we_wb), .rd_wb(rd_wb), .data_wb(data_wb),
    .pc_wb(pc_wb), .have_inst(have_inst), .rs1_id(rs1_id), .rs2_id(rs2_id), .rD1(s_rD1), .rD2(s_rD2),
    .dbg_addr(dbg_addr), .dbg_data(s_dbg), .instret(s_instret), .last_pc(s_last_pc),
    .last_rd(s_last_rd), .last_data(s_last_data)
  );

  logic [31:0] m_regs [32];
  logic [63:0] m_instret;
  logic [31:0] m_last_pc, m_last_data;
  logic [4:0]  m_last_rd;

  always @(posedge clk_cpu or posedge rst_cpu) begin
    if (rst_cpu) begin
      for (int i = 0; i < 32; i++) m_regs[i] <= (i == 2) ? SP : 32'h0;
      m_instret <= 0;
      m_last_pc <= 0;
      m_last_rd <= 0;
      m_last_data <= 0;
    end else begin
      if (rd_we_wb && rd_wb != 0) m_regs[rd_wb] <= data_wb;
      if (have_inst) begin
        m_instret <= m_instret + 1;
        m_last_pc <= pc_wb;
        m_last_rd <= rd_we_wb ? rd_wb : 5'd0;
        m_last_data <= (rd_we_wb && rd_wb != 0) ? data_wb : 32'h0;
      end
    end
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (rd_we_wb && rd_wb == a) return data_wb;
    return m_regs[a];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk_cpu) begin
    chk("rD1", 64'(rD1), 64'(exp_rd(rs1_id)));
    chk("rD2", 64'(rD2), 64'(exp_rd(rs2_id)));
    chk("dbg_data", 64'(dbg_data), 64'(dbg_addr == 0 ? 32'h0 : m_regs[dbg_addr]));
    chk("instret", instret, m_instret);
    chk("last_pc", 64'(last_pc), 64'(m_last_pc));
    chk("last_rd", 64'(last_rd), 64'(m_last_rd));
    chk("last_data", 64'(last_data), 64'(m_last_data));
    chk("small_instret", 64'(s_instret), 64'(m_instret[3:0]));
    chk("small_rD1", 64'(s_rD1), 64'(rD1));
  end

  task automatic tick;
    @(posedge clk_cpu);
    @(negedge clk_cpu);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] rd, input logic [31:0] d,
                       input logic [31:0] pc, input logic hi, input logic [4:0] a1, input logic [4:0] a2);
    rd_we_wb = we; rd_wb = rd; data_wb = d; pc_wb = pc; have_inst = hi; rs1_id = a1; rs2_id = a2;
  endtask

  initial begin
    rst_cpu = 1;
    @(negedge clk_cpu);
    #1 rst_cpu = 0;
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1 chk("reset_dbg", 64'(dbg_data), (i == 2) ? 64'(SP) : 64'h0);
    end
    chk("reset_instret", instret, 64'h0);
    tick;
    drive(1, 5, 32'hDEAD_BEEF, 0, 0, 5, 0);
    #1 chk("bypass_rD1", 64'(rD1), 64'hDEAD_BEEF);
    tick;
    rd_we_wb = 0;
    #1 chk("array_rD1", 64'(rD1), 64'hDEAD_BEEF);
    drive(1, 0, 32'h1234, 0, 0, 0, 0);
    #1 chk("x0_rD1_pre", 64'(rD1), 64'h0);
    chk("x0_rD2_pre", 64'(rD2), 64'h0);
    tick;
    rd_we_wb = 0; dbg_addr = 0;
    #1 chk("x0_rD1_post", 64'(rD1), 64'h0);
    chk("x0_dbg_post", 64'(dbg_data), 64'h0);
    drive(0, 0, 0, 0, 1, 0, 0); tick;
    drive(0, 0, 0, 4, 1, 0, 0); tick;
    drive(1, 7, 32'h55, 8, 1, 0, 0); tick;
    drive(1, 9, 32'hAA, 12, 0, 0, 0);
    #1 chk("commit_instret", instret, 64'd3);
    chk("commit_pc", 64'(last_pc), 64'd8);
    chk("commit_rd", 64'(last_rd), 64'd7);
    chk("commit_data", 64'(last_data), 64'h55);
    tick;
    rd_we_wb = 0; dbg_addr = 9;
    #1 chk("nocommit_instret", instret, 64'd3);
    chk("nocommit_write", 64'(dbg_data), 64'hAA);
    for (int i = 0; i < 13; i++) begin
      drive(0, 0, 0, 32'(i), 1, 0, 0); tick;
    end
    have_inst = 0;
    #1 chk("wrap_small", 64'(s_instret), 64'h0);
    chk("wrap_big", instret, 64'd16);
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] rd;
      rd = 5'($urandom_range(0, 31));
      drive($urandom_range(0, 3) != 0, rd, $urandom, $urandom, $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1 ? rd : 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 7) == 0) rs2_id = rs1_id;
      dbg_addr = 5'($urandom_range(0, 31));
      tick;
    end
    for (int i = 1; i < 32; i++) begin
      drive(1, 5'(i), 32'(i) * 32'h0101_0101, 32'(i), 1, 0, 0); tick;
    end
    drive(1, 3, 32'hCAFE_F00D, 32'h100, 1, 0, 0);
    dbg_addr = 1;
    #2 rst_cpu = 1;
    #1 chk("midrst_instret", instret, 64'h0);
    chk("midrst_last_pc", 64'(last_pc), 64'h0);
    chk("midrst_last_rd", 64'(last_rd), 64'h0);
    chk("midrst_last_data", 64'(last_data), 64'h0);
    chk("midrst_x1", 64'(dbg_data), 64'h0);
    for (int i = 2; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1 chk("midrst_dbg", 64'(dbg_data), (i == 2) ? 64'(SP) : 64'h0);
    end
    @(negedge clk_cpu);
    #1 rst_cpu = 0;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick;
    tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
